// File: rtl/alu_md.sv
// alu_md: EX-stage ALU for the multicycle CPU with an iterative
// multiply/divide unit and HI/LO registers.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ALUOp                00 add, 01 sub, 10 decode funct, 11 zero
//   ALUSrcA              0: PC, 1: regA
//   ALUSrcB              00 regB, 01 PC_INC, 10 sext(imm), 11 sext(imm)<<2
//   funct                R-type function field
//   md_start             start the mul/div op selected by funct (IDLE only)
//   PC, regA, regB       operands
//   IR_low16             immediate field
//   result, zero         combinational ALU result and its zero flag
//   ALUOut               result registered every clock
//   busy, done           mul/div handshake (done is a one-cycle pulse)
//   hi, lo               HI/LO registers
module alu_md #(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic             ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [5:0]       funct,
  input  logic             md_start,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [15:0]      IR_low16,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] ALUOut,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ALU datapath
  logic [WIDTH-1:0] a_op_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] imm_ext_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] alu_out_r;

  // mul/div state
  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] acc_r;      // partial product high half / partial remainder
  logic [WIDTH-1:0] mq_r;       // multiplier / quotient shift register
  logic [WIDTH-1:0] opd_r;      // multiplicand / divisor magnitude
  logic             is_div_r;
  logic             neg_res_r;  // product or quotient must be negated
  logic             neg_rem_r;  // remainder takes the dividend's sign
  logic             dz_r;       // divisor was zero
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // capture-time decode
  logic             md_go_s;
  logic             sa_s;
  logic             sb_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;

  // one iteration of the shared shift datapath
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [WIDTH-1:0]   acc_n_s;
  logic [WIDTH-1:0]   mq_n_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;

  assign imm_ext_s = {{(WIDTH-16){IR_low16[15]}}, IR_low16};

  // Operand source selection
  always_comb begin
    if (ALUSrcA) begin
      a_op_s = regA;
    end else begin
      a_op_s = PC;
    end
    case (ALUSrcB)
      2'b00:   b_op_s = regB;
      2'b01:   b_op_s = WIDTH'(PC_INC);
      2'b10:   b_op_s = imm_ext_s;
      2'b11:   b_op_s = imm_ext_s << 2;
      default: b_op_s = regB;
    endcase
  end

  // ALU function decode
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (ALUOp)
      2'b00: result_s = a_op_s + b_op_s;
      2'b01: result_s = a_op_s - b_op_s;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: result_s = a_op_s + b_op_s;
          6'b100010, 6'b100011: result_s = a_op_s - b_op_s;
          6'b100100: result_s = a_op_s & b_op_s;
          6'b100101: result_s = a_op_s | b_op_s;
          6'b100110: result_s = a_op_s ^ b_op_s;
          6'b100111: result_s = ~(a_op_s | b_op_s);
          6'b101010: result_s = {{(WIDTH-1){1'b0}}, ($signed(a_op_s) < $signed(b_op_s))};
          6'b101011: result_s = {{(WIDTH-1){1'b0}}, (a_op_s < b_op_s)};
          6'b010000: result_s = hi_r;
          6'b010010: result_s = lo_r;
          default:   result_s = {WIDTH{1'b0}};
        endcase
      end
      2'b11:   result_s = {WIDTH{1'b0}};
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  assign result = result_s;
  assign zero   = (result_s == {WIDTH{1'b0}});

  // ALUOut register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r <= {WIDTH{1'b0}};
    end else begin
      alu_out_r <= result_s;
    end
  end

  // Start qualification and operand magnitudes; funct[0]=0 selects the signed op
  always_comb begin
    md_go_s = md_start && (state_r == S_IDLE) && (funct[5:2] == 4'b0110);
    sa_s    = ~funct[0] & regA[WIDTH-1];
    sb_s    = ~funct[0] & regB[WIDTH-1];
    if (sa_s) begin
      mag_a_s = {WIDTH{1'b0}} - regA;
    end else begin
      mag_a_s = regA;
    end
    if (sb_s) begin
      mag_b_s = {WIDTH{1'b0}} - regB;
    end else begin
      mag_b_s = regB;
    end
  end

  // One shift-add or restoring-subtract step. A negative trial difference
  // shows up in bit WIDTH because the shifted remainder is below 2*divisor.
  always_comb begin
    if (mq_r[0]) begin
      mul_sum_s = {1'b0, acc_r} + {1'b0, opd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r};
    end
    div_shift_s = {acc_r, mq_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opd_r};
    if (is_div_r) begin
      if (div_diff_s[WIDTH]) begin
        acc_n_s = div_shift_s[WIDTH-1:0];
      end else begin
        acc_n_s = div_diff_s[WIDTH-1:0];
      end
      mq_n_s = {mq_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
    end else begin
      acc_n_s = mul_sum_s[WIDTH:1];
      mq_n_s  = {mul_sum_s[0], mq_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step; divide-by-zero forces an all-ones
  // quotient while the remainder path already yields the dividend.
  always_comb begin
    prod_s = {acc_n_s, mq_n_s};
    if (neg_res_r) begin
      prod_fix_s = {(2*WIDTH){1'b0}} - prod_s;
    end else begin
      prod_fix_s = prod_s;
    end
    if (is_div_r) begin
      if (dz_r) begin
        fin_lo_s = {WIDTH{1'b1}};
      end else if (neg_res_r) begin
        fin_lo_s = {WIDTH{1'b0}} - mq_n_s;
      end else begin
        fin_lo_s = mq_n_s;
      end
      if (neg_rem_r) begin
        fin_hi_s = {WIDTH{1'b0}} - acc_n_s;
      end else begin
        fin_hi_s = acc_n_s;
      end
    end else begin
      fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Mul/div FSM, iteration registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      acc_r     <= {WIDTH{1'b0}};
      mq_r      <= {WIDTH{1'b0}};
      opd_r     <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (md_go_s) begin
            state_r   <= S_RUN;
            busy_r    <= 1'b1;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            mq_r      <= mag_a_s;
            opd_r     <= mag_b_s;
            is_div_r  <= funct[1];
            neg_res_r <= sa_s ^ sb_s;
            neg_rem_r <= sa_s;
            dz_r      <= (regB == {WIDTH{1'b0}});
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_RUN: begin
          acc_r <= acc_n_s;
          mq_r  <= mq_n_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_STEP) begin
            hi_r    <= fin_hi_s;
            lo_r    <= fin_lo_s;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            done_r <= 1'b0;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ALUOut = alu_out_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign hi     = hi_r;
  assign lo     = lo_r;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): directed steps plus randomized
// ALU and mul/div operations checked against an arithmetic reference model.
module tb_alu_md;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [1:0]    ALUOp;
  logic          ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [5:0]    funct;
  logic          md_start;
  logic [W-1:0]  PC;
  logic [W-1:0]  regA;
  logic [W-1:0]  regB;
  logic [15:0]   IR_low16;
  logic [W-1:0]  result;
  logic [W-1:0]  ALUOut;
  logic          zero;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  // model copy of HI/LO
  logic [W-1:0] m_hi = 32'h0;
  logic [W-1:0] m_lo = 32'h0;

  alu_md #(.WIDTH(W), .PC_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .funct(funct), .md_start(md_start), .PC(PC), .regA(regA), .regB(regB),
    .IR_low16(IR_low16), .result(result), .ALUOut(ALUOut), .zero(zero),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference mul/div from plain signed/unsigned 64-bit arithmetic
  function automatic void md_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    h = 32'h0;
    l = 32'h0;
    case (f)
      6'b011000: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      6'b011001: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      6'b011010: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 32'h0; l = a; end
        else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
      end
      6'b011011: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      end
      default: begin h = 32'h0; l = 32'h0; end
    endcase
  endfunction

  // Reference ALU result from the current inputs and model HI/LO
  function automatic logic [W-1:0] alu_ref();
    logic [W-1:0] a, b, sext;
    sext = {{16{IR_low16[15]}}, IR_low16};
    a = ALUSrcA ? regA : PC;
    case (ALUSrcB)
      2'b00:   b = regB;
      2'b01:   b = 32'd1;
      2'b10:   b = sext;
      default: b = sext * 32'd4;
    endcase
    case (ALUOp)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: return a + b;
          6'b100010, 6'b100011: return a - b;
          6'b100100: return a & b;
          6'b100101: return a | b;
          6'b100110: return a ^ b;
          6'b100111: return ~(a | b);
          6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'b101011: return (a < b) ? 32'd1 : 32'd0;
          6'b010000: return m_hi;
          6'b010010: return m_lo;
          default:   return 32'd0;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  // Apply current ALU inputs, check result/zero, then ALUOut after the edge
  task automatic alu_check(input string tag, input logic [W-1:0] exp);
    #1;
    check({tag, " result"}, result, exp);
    check({tag, " zero"}, zero, (exp == 32'h0));
    step();
    check({tag, " ALUOut"}, ALUOut, exp);
  endtask

  // Run one mul/div op with full latency and handshake checks. With inject set,
  // a second multu start is pulsed mid-run and must be ignored.
  task automatic do_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit inject);
    logic [W-1:0] eh, el;
    int pulses;
    md_ref(f, a, b, eh, el);
    funct = f; regA = a; regB = b; md_start = 1'b1;
    step();  // edge 0
    md_start = 1'b0;
    check({tag, " busy@1"}, busy, 1'b1);
    check({tag, " done@1"}, done, 1'b0);
    // scramble operands after capture; read LO through the ALU meanwhile
    regA = $urandom; regB = $urandom;
    ALUOp = 2'b10; funct = 6'b010010;
    pulses = 0;
    for (int e = 1; e < W; e++) begin
      if (inject && e == 5) begin
        funct = 6'b011001; regA = 32'h0000_0003; regB = 32'h0000_0005; md_start = 1'b1;
      end
      step();
      if (inject && e == 5) begin
        md_start = 1'b0; funct = 6'b010010;
      end
      if (done) pulses++;
      check({tag, " busy run"}, busy, 1'b1);
      check({tag, " hilo hold"}, {hi, lo}, {m_hi, m_lo});
      if (!(inject && e == 5)) check({tag, " mflo old"}, result, m_lo);
    end
    check({tag, " no early done"}, pulses, 0);
    step();  // edge W
    check({tag, " done@W"}, done, 1'b1);
    check({tag, " busy@W"}, busy, 1'b1);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    m_hi = eh; m_lo = el;
    step();  // edge W+1
    check({tag, " done@W+1"}, done, 1'b0);
    check({tag, " busy@W+1"}, busy, 1'b0);
    funct = 6'b010000;
    #1;
    check({tag, " mfhi"}, result, eh);
    step();
    check({tag, " stays idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [5:0] ftab [16];
    logic [5:0] mdtab [4];
    logic [W-1:0] ra, rb;
    int sel, pulses;
    ftab = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
             6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b010000, 6'b010010,
             6'b011000, 6'b000000, 6'b111111, 6'b010001};
    mdtab = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

    rst_n = 1'b0; ALUOp = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b00; funct = 6'h0;
    md_start = 1'b0; PC = 32'h0; regA = 32'h0; regB = 32'h0; IR_low16 = 16'h0;
    #1;
    check("rst ALUOut", ALUOut, 32'h0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // directed ALU cases
    ALUOp = 2'b10; funct = 6'b100000; ALUSrcA = 1'b1; ALUSrcB = 2'b00; regA = 32'd5; regB = 32'd7;
    alu_check("add 5+7", 32'd12);
    funct = 6'b100010; regA = 32'd7; regB = 32'd7;
    alu_check("sub 7-7", 32'd0);
    ALUOp = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b11; IR_low16 = 16'hFFFF; PC = 32'h100;
    alu_check("pc+imm<<2", 32'hFC);
    ALUSrcB = 2'b01;
    alu_check("pc+inc", 32'h101);
    ALUOp = 2'b11; ALUSrcA = 1'b1; regA = 32'h55;
    alu_check("op11 zero", 32'h0);
    ALUOp = 2'b10; funct = 6'b101010; ALUSrcB = 2'b00; regA = 32'hFFFF_FFFF; regB = 32'd1;
    alu_check("slt -1<1", 32'd1);
    funct = 6'b101011;
    alu_check("sltu big<1", 32'd0);

    // directed mul/div cases
    do_md("mult", 6'b011000, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_md("multu", 6'b011001, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_md("divu", 6'b011011, 32'd100, 32'd7, 1'b0);
    do_md("div neg", 6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_md("div by 0", 6'b011010, 32'h1234, 32'h0, 1'b0);
    do_md("div min/-1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_md("handshake", 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // reset in the middle of a run
    funct = 6'b011000; regA = 32'hFFFF_FFFD; regB = 32'd7; md_start = 1'b1;
    step();
    md_start = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    check("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort ALUOut", ALUOut, 32'h0);
    check("abort done", done, 1'b0);
    m_hi = 32'h0; m_lo = 32'h0;
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < W + 4; e++) begin
      step();
      if (done || busy) pulses++;
    end
    check("no done after abort", pulses, 0);
    do_md("mult 3x4", 6'b011000, 32'd3, 32'd4, 1'b0);

    // randomized mul/div
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 7);
      ra = $urandom; rb = $urandom;
      case (sel)
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        3: begin ra = -$urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        default: ;
      endcase
      do_md("rand md", mdtab[$urandom_range(0, 3)], ra, rb, 1'b0);
    end

    // randomized single-cycle ALU ops
    for (int i = 0; i < 40; i++) begin
      ALUOp = 2'($urandom); ALUSrcA = 1'($urandom); ALUSrcB = 2'($urandom);
      funct = ftab[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) funct = 6'($urandom);
      PC = $urandom; regA = $urandom; regB = $urandom; IR_low16 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) regB = regA;
      alu_check("rand alu", alu_ref());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
